// File: rtl/mmcm_ps_pkg.sv
// -----------------------------------------------------------------------------
// mmcm_ps_pkg
// Shared definitions for the multi-channel MMCM dynamic phase-shift stepper.
//   ps_state_e : per-channel FSM state encoding.
//   ps_clamp   : signed magnitude clamp. It works on 32-bit values so any step
//                width up to 32 bits can use it. Callers sign-extend the input
//                and truncate the result.
// -----------------------------------------------------------------------------
package mmcm_ps_pkg;

  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_PULSE = 3'd1,
    PS_WAIT  = 3'd2,
    PS_DONE  = 3'd3,
    PS_ERROR = 3'd4   // only reachable when MMCM_PS_TIMEOUT_EN is defined
  } ps_state_e;

  // Clamp a signed value to the range [-limit, +limit]. The comparison is signed.
  function automatic logic signed [31:0] ps_clamp(input logic signed [31:0] value,
                                                   input logic signed [31:0] limit);
    if (value > limit) begin
      return limit;
    end else if (value < -limit) begin
      return -limit;
    end
    return value;
  endfunction

endpackage

// File: rtl/mmcm_ps_channel.sv
// -----------------------------------------------------------------------------
// mmcm_ps_channel
// Drives one MMCM dynamic phase-shift port. A load latches a clamped signed
// target. The channel then issues one PSEN pulse at a time, waits for PSDONE
// after each pulse, and keeps a signed position count. When the position equals
// the target, the channel pulses o_done.
//
// Optional feature (macro MMCM_PS_TIMEOUT_EN): a PSDONE timeout. If PSDONE does
// not arrive within pTIMEOUT cycles, the channel sets a sticky o_error and parks
// in PS_ERROR. Only i_mmcm_reset or reset can release it.
//
// Ports
//   clk_usb       : clock (also the MMCM PSCLK)
//   reset         : asynchronous, active-high
//   i_step_index  : signed target step index
//   i_load        : load strobe (a load while busy retargets the channel)
//   i_mmcm_reset  : MMCM held in reset; position and target return to 0
//   i_psdone      : MMCM PSDONE
//   o_psen        : MMCM PSEN (one-cycle pulses)
//   o_psincdec    : MMCM PSINCDEC
//   o_done        : one-cycle pulse when the target is reached
//   o_busy        : high from load acceptance until o_done
//   o_position    : current signed position
//   o_error       : sticky PSDONE timeout flag (0 when the feature is absent)
// -----------------------------------------------------------------------------
module mmcm_ps_channel
  import mmcm_ps_pkg::*;
#(
  parameter int pSTEP_WIDTH = 16,
  parameter int pMAX_STEP   = 1120,
  parameter int pTIMEOUT    = 1023
) (
  input  logic                          clk_usb,
  input  logic                          reset,
  input  logic signed [pSTEP_WIDTH-1:0] i_step_index,
  input  logic                          i_load,
  input  logic                          i_mmcm_reset,
  input  logic                          i_psdone,
  output logic                          o_psen,
  output logic                          o_psincdec,
  output logic                          o_done,
  output logic                          o_busy,
  output logic signed [pSTEP_WIDTH-1:0] o_position,
  output logic                          o_error
);

  // Reject parameter sets that could let the position counter wrap.
  if (pMAX_STEP < 0 || pMAX_STEP >= (2 ** (pSTEP_WIDTH - 1)) || pTIMEOUT < 1) begin : g_param_check
    $error("mmcm_ps_channel: pMAX_STEP must be < 2^(pSTEP_WIDTH-1) and pTIMEOUT >= 1");
  end

  ps_state_e                   r_state;
  ps_state_e                   w_state_next;
  logic signed [pSTEP_WIDTH-1:0] r_target;
  logic signed [pSTEP_WIDTH-1:0] w_target_next;
  logic signed [pSTEP_WIDTH-1:0] r_position;
  logic signed [pSTEP_WIDTH-1:0] w_position_next;
  logic signed [pSTEP_WIDTH-1:0] w_load_target;
  logic r_psen,     w_psen_next;
  logic r_psincdec, w_psincdec_next;
  logic r_done,     w_done_next;
  logic r_busy,     w_busy_next;

`ifdef MMCM_PS_TIMEOUT_EN
  localparam int TIMER_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
  logic [TIMER_W-1:0] r_timer, w_timer_next;
  logic               r_error, w_error_next;
`endif

  // Sign-extend to the package width, clamp, then narrow back. The clamp bound
  // fits in pSTEP_WIDTH, so the truncation loses nothing.
  assign w_load_target = pSTEP_WIDTH'(ps_clamp(32'(i_step_index), 32'(pMAX_STEP)));

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_target_next   = r_target;
    w_position_next = r_position;
    w_psen_next     = 1'b0;
    w_psincdec_next = r_psincdec;
    w_done_next     = 1'b0;
    w_busy_next     = r_busy;
`ifdef MMCM_PS_TIMEOUT_EN
    w_timer_next    = r_timer;
    w_error_next    = r_error;
`endif

    if (i_mmcm_reset) begin
      // The MMCM's phase returns to zero while it is held in reset. Any step in
      // flight is abandoned and loads are ignored.
      w_state_next    = PS_IDLE;
      w_target_next   = '0;
      w_position_next = '0;
      w_psincdec_next = 1'b0;
      w_busy_next     = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
      w_error_next    = 1'b0;
`endif
    end else begin
      case (r_state)
        PS_IDLE: begin
          w_psincdec_next = 1'b0;
          if (i_load) begin
            w_target_next = w_load_target;
            w_busy_next   = 1'b1;
            w_state_next  = PS_PULSE;
          end
        end

        PS_PULSE: begin
          // A retarget here is latched, but this decision still uses the old
          // target. The new target applies from the next PULSE.
          if (i_load) begin
            w_target_next = w_load_target;
          end
          if (r_target > r_position) begin
            w_psen_next     = 1'b1;
            w_psincdec_next = 1'b1;
            w_position_next = r_position + pSTEP_WIDTH'(1);
            w_state_next    = PS_WAIT;
`ifdef MMCM_PS_TIMEOUT_EN
            w_timer_next    = '0;
`endif
          end else if (r_target < r_position) begin
            w_psen_next     = 1'b1;
            w_psincdec_next = 1'b0;
            w_position_next = r_position - pSTEP_WIDTH'(1);
            w_state_next    = PS_WAIT;
`ifdef MMCM_PS_TIMEOUT_EN
            w_timer_next    = '0;
`endif
          end else begin
            w_state_next = PS_DONE;
          end
        end

        PS_WAIT: begin
          if (i_load) begin
            w_target_next = w_load_target;
          end
          if (i_psdone) begin
            w_state_next = PS_PULSE;
`ifdef MMCM_PS_TIMEOUT_EN
          end else if (r_timer == TIMER_W'(pTIMEOUT - 1)) begin
            w_error_next    = 1'b1;
            w_busy_next     = 1'b0;
            w_psincdec_next = 1'b0;
            w_state_next    = PS_ERROR;
          end else begin
            w_timer_next = r_timer + TIMER_W'(1);
`endif
          end
        end

        PS_DONE: begin
          w_done_next     = 1'b1;
          w_busy_next     = 1'b0;
          w_psincdec_next = 1'b0;
          w_state_next    = PS_IDLE;
        end

`ifdef MMCM_PS_TIMEOUT_EN
        PS_ERROR: begin
          // Parked until i_mmcm_reset or reset. Loads are ignored.
          w_busy_next     = 1'b0;
          w_psincdec_next = 1'b0;
        end
`endif

        default: begin
          w_state_next = PS_IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // samples the pre-edge values and none depends on evaluation order.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      r_state    <= PS_IDLE;
      r_target   <= '0;
      r_position <= '0;
      r_psen     <= 1'b0;
      r_psincdec <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
      r_timer    <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_target   <= w_target_next;
      r_position <= w_position_next;
      r_psen     <= w_psen_next;
      r_psincdec <= w_psincdec_next;
      r_done     <= w_done_next;
      r_busy     <= w_busy_next;
`ifdef MMCM_PS_TIMEOUT_EN
      r_timer    <= w_timer_next;
      r_error    <= w_error_next;
`endif
    end
  end

  assign o_psen     = r_psen;
  assign o_psincdec = r_psincdec;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_position = r_position;
`ifdef MMCM_PS_TIMEOUT_EN
  assign o_error    = r_error;
`else
  assign o_error    = 1'b0;
`endif

endmodule

// File: rtl/mmcm_phaseshift_multi.sv
// -----------------------------------------------------------------------------
// mmcm_phaseshift_multi
// Holds pCHANNELS independent MMCM dynamic phase-shift steppers, all clocked by
// clk_usb. Each channel takes its slice of the flat buses; channel i uses bits
// [i*pSTEP_WIDTH +: pSTEP_WIDTH] of I_step_index and O_position.
//
// Optional feature (macro MMCM_PS_TIMEOUT_EN): a per-channel PSDONE timeout
// that sets a sticky error flag (see mmcm_ps_channel).
//
// Ports (all per-channel vectors are pCHANNELS wide)
//   clk_usb      : clock for all logic and PSCLK of every MMCM
//   reset        : asynchronous, active-high
//   I_step_index : signed targets, pCHANNELS*pSTEP_WIDTH
//   I_load       : load strobes
//   I_mmcm_reset : MMCM-in-reset indications (position re-zeroed)
//   I_psdone     : MMCM PSDONE
//   O_psen       : MMCM PSEN
//   O_psincdec   : MMCM PSINCDEC
//   O_done       : target-reached pulses
//   O_busy       : channel stepping
//   O_position   : signed positions, pCHANNELS*pSTEP_WIDTH
//   O_error      : sticky PSDONE timeout flags
// -----------------------------------------------------------------------------
module mmcm_phaseshift_multi
  import mmcm_ps_pkg::*;
#(
  parameter int pCHANNELS   = 2,
  parameter int pSTEP_WIDTH = 16,
  parameter int pMAX_STEP   = 1120,
  parameter int pTIMEOUT    = 1023
) (
  input  logic                             clk_usb,
  input  logic                             reset,
  input  logic [pCHANNELS*pSTEP_WIDTH-1:0] I_step_index,
  input  logic [pCHANNELS-1:0]             I_load,
  input  logic [pCHANNELS-1:0]             I_mmcm_reset,
  input  logic [pCHANNELS-1:0]             I_psdone,
  output logic [pCHANNELS-1:0]             O_psen,
  output logic [pCHANNELS-1:0]             O_psincdec,
  output logic [pCHANNELS-1:0]             O_done,
  output logic [pCHANNELS-1:0]             O_busy,
  output logic [pCHANNELS*pSTEP_WIDTH-1:0] O_position,
  output logic [pCHANNELS-1:0]             O_error
);

  if (pCHANNELS < 1 || pCHANNELS > 8) begin : g_param_check
    $error("mmcm_phaseshift_multi: pCHANNELS must be in 1..8");
  end

  for (genvar g = 0; g < pCHANNELS; g++) begin : g_ch
    mmcm_ps_channel #(
      .pSTEP_WIDTH (pSTEP_WIDTH),
      .pMAX_STEP   (pMAX_STEP),
      .pTIMEOUT    (pTIMEOUT)
    ) u_channel (
      .clk_usb      (clk_usb),
      .reset        (reset),
      .i_step_index (I_step_index[g*pSTEP_WIDTH +: pSTEP_WIDTH]),
      .i_load       (I_load[g]),
      .i_mmcm_reset (I_mmcm_reset[g]),
      .i_psdone     (I_psdone[g]),
      .o_psen       (O_psen[g]),
      .o_psincdec   (O_psincdec[g]),
      .o_done       (O_done[g]),
      .o_busy       (O_busy[g]),
      .o_position   (O_position[g*pSTEP_WIDTH +: pSTEP_WIDTH]),
      .o_error      (O_error[g])
    );
  end

endmodule

// File: tb/tb_mmcm_phaseshift_multi.sv
// -----------------------------------------------------------------------------
// tb_mmcm_phaseshift_multi
// Directed bench for mmcm_phaseshift_multi with two channels. A PSDONE
// responder per channel answers each PSEN pulse after a programmable latency.
// A negedge monitor counts PSEN pulses, increments and O_done pulses per
// channel. Expected values are worked out by hand from the stimulus. Build with
// MMCM_PS_TIMEOUT_EN to add the timeout scenario.
// -----------------------------------------------------------------------------
module tb_mmcm_phaseshift_multi;

  localparam int CH   = 2;
  localparam int W    = 16;
  localparam int MAXS = 1120;
`ifdef MMCM_PS_TIMEOUT_EN
  localparam int TMO  = 15;
`else
  localparam int TMO  = 1023;
`endif

  logic              clk_usb = 1'b0;
  logic              reset;
  logic [CH*W-1:0]   I_step_index;
  logic [CH-1:0]     I_load;
  logic [CH-1:0]     I_mmcm_reset;
  logic [CH-1:0]     I_psdone;
  logic [CH-1:0]     O_psen;
  logic [CH-1:0]     O_psincdec;
  logic [CH-1:0]     O_done;
  logic [CH-1:0]     O_busy;
  logic [CH*W-1:0]   O_position;
  logic [CH-1:0]     O_error;

  logic psdone_q [CH];
  int   lat      [CH] = '{3, 3};
  bit   ps_en    [CH] = '{1'b1, 1'b1};
  int   psen_cnt [CH] = '{0, 0};
  int   inc_cnt  [CH] = '{0, 0};
  int   done_cnt [CH] = '{0, 0};

  int n_checks = 0;
  int n_errors = 0;

  assign I_psdone = {psdone_q[1], psdone_q[0]};

  always #5 clk_usb = ~clk_usb;

  mmcm_phaseshift_multi #(
    .pCHANNELS   (CH),
    .pSTEP_WIDTH (W),
    .pMAX_STEP   (MAXS),
    .pTIMEOUT    (TMO)
  ) dut (
    .clk_usb      (clk_usb),
    .reset        (reset),
    .I_step_index (I_step_index),
    .I_load       (I_load),
    .I_mmcm_reset (I_mmcm_reset),
    .I_psdone     (I_psdone),
    .O_psen       (O_psen),
    .O_psincdec   (O_psincdec),
    .O_done       (O_done),
    .O_busy       (O_busy),
    .O_position   (O_position),
    .O_error      (O_error)
  );

  // PSDONE responder: PSDONE goes high lat cycles after PSEN is seen, for one cycle.
  for (genvar g = 0; g < CH; g++) begin : g_psdone
    initial begin
      psdone_q[g] = 1'b0;
      forever begin
        @(posedge clk_usb); #1;
        if (O_psen[g] && ps_en[g]) begin
          repeat (lat[g]) @(posedge clk_usb);
          #1 psdone_q[g] = 1'b1;
          @(posedge clk_usb); #1 psdone_q[g] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk_usb) begin
    for (int c = 0; c < CH; c++) begin
      if (O_psen[c]) begin
        psen_cnt[c]++;
        if (O_psincdec[c]) inc_cnt[c]++;
      end
      if (O_done[c]) done_cnt[c]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pos_of(input int c);
    return O_position[c*W +: W];
  endfunction

  task automatic drive_load(input logic [CH-1:0] mask, input logic [W-1:0] v);
    @(negedge clk_usb);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        I_step_index[c*W +: W] = v;
        I_load[c] = 1'b1;
      end
    end
    @(negedge clk_usb);
    I_load = '0;
  endtask

  // Holds the MMCM reset for two cycles with a load asserted, which must be ignored.
  task automatic mmcm_rst(input logic [CH-1:0] mask);
    @(negedge clk_usb);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) I_step_index[c*W +: W] = 16'd7;
    end
    I_mmcm_reset = mask;
    I_load       = mask;
    repeat (2) @(negedge clk_usb);
    I_mmcm_reset = '0;
    I_load       = '0;
  endtask

  task automatic wait_done(input int c, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_usb);
      if (O_done[c]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, seen0, seen1;
    int p0, i0, d0, p1, i1, d1;

    reset        = 1'b1;
    I_step_index = '0;
    I_load       = '0;
    I_mmcm_reset = '0;
    repeat (3) @(negedge clk_usb);
    check("rst_psen",     32'(O_psen),     32'd0);
    check("rst_psincdec", 32'(O_psincdec), 32'd0);
    check("rst_done",     32'(O_done),     32'd0);
    check("rst_busy",     32'(O_busy),     32'd0);
    check("rst_position", O_position,      32'd0);
    check("rst_error",    32'(O_error),    32'd0);
    reset = 1'b0;

    // ---- Load +3 on ch0 with PSDONE latency 3; checks first-PSEN latency ----
    lat[0] = 3;
    p0 = psen_cnt[0]; i0 = inc_cnt[0]; d0 = done_cnt[0];
    @(negedge clk_usb);
    I_step_index[0 +: W] = 16'd3;
    I_load[0] = 1'b1;
    @(posedge clk_usb); #1;
    check("a_busy_on_load", 32'(O_busy[0]), 32'd1);
    check("a_psen_not_yet", 32'(O_psen[0]), 32'd0);
    @(negedge clk_usb);
    I_load[0] = 1'b0;
    @(posedge clk_usb); #1;
    check("a_first_psen",    32'(O_psen[0]),     32'd1);
    check("a_first_incdec",  32'(O_psincdec[0]), 32'd1);
    wait_done(0, 200, seen);
    check("a_done_seen",     32'(seen),          32'd1);
    check("a_busy_with_done", 32'(O_busy[0]),    32'd0);
    check("a_position",      32'(pos_of(0)),     32'd3);
    repeat (5) @(negedge clk_usb);
    check("a_psen_pulses",   32'(psen_cnt[0] - p0), 32'd3);
    check("a_inc_pulses",    32'(inc_cnt[0] - i0),  32'd3);
    check("a_done_pulses",   32'(done_cnt[0] - d0), 32'd1);
    check("a_ch1_position",  32'(pos_of(1)),        32'd0);
    check("a_ch1_psen",      32'(psen_cnt[1]),      32'd0);
    check("a_ch1_done",      32'(done_cnt[1]),      32'd0);
    check("a_ch1_busy",      32'(O_busy[1]),        32'd0);

    // ---- From +3 load -2: five decrements ----
    p0 = psen_cnt[0]; i0 = inc_cnt[0]; d0 = done_cnt[0];
    drive_load(2'b01, 16'hFFFE);
    wait_done(0, 300, seen);
    check("b_done_seen",   32'(seen),             32'd1);
    check("b_position",    32'(pos_of(0)),        32'h0000_FFFE);
    repeat (5) @(negedge clk_usb);
    check("b_psen_pulses", 32'(psen_cnt[0] - p0), 32'd5);
    check("b_inc_pulses",  32'(inc_cnt[0] - i0),  32'd0);
    check("b_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    // ---- Load 5000: clamps to +1120 (1122 steps from -2) ----
    lat[0] = 1;
    p0 = psen_cnt[0]; i0 = inc_cnt[0]; d0 = done_cnt[0];
    drive_load(2'b01, 16'd5000);
    wait_done(0, 6000, seen);
    check("c_done_seen",   32'(seen),             32'd1);
    check("c_position",    32'(pos_of(0)),        32'd1120);
    repeat (3) @(negedge clk_usb);
    check("c_psen_pulses", 32'(psen_cnt[0] - p0), 32'd1122);
    check("c_inc_pulses",  32'(inc_cnt[0] - i0),  32'd1122);
    check("c_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    // Equal target: O_done after the second edge following the load edge, no PSEN.
    p0 = psen_cnt[0];
    @(negedge clk_usb);
    I_step_index[0 +: W] = 16'd1120;
    I_load[0] = 1'b1;
    @(posedge clk_usb); #1;
    check("c_eq_done_n0", 32'(O_done[0]), 32'd0);
    @(negedge clk_usb);
    I_load[0] = 1'b0;
    @(posedge clk_usb); #1;
    check("c_eq_done_n1", 32'(O_done[0]), 32'd0);
    @(posedge clk_usb); #1;
    check("c_eq_done_n2", 32'(O_done[0]), 32'd1);
    check("c_eq_busy_n2", 32'(O_busy[0]), 32'd0);
    repeat (3) @(negedge clk_usb);
    check("c_eq_no_psen", 32'(psen_cnt[0] - p0), 32'd0);

    // Negative clamp from zero: -5000 goes to -1120.
    mmcm_rst(2'b01);
    check("c_mrst_position", 32'(pos_of(0)), 32'd0);
    check("c_mrst_busy",     32'(O_busy[0]), 32'd0);
    p0 = psen_cnt[0]; i0 = inc_cnt[0];
    drive_load(2'b01, 16'hEC78);
    wait_done(0, 6000, seen);
    check("c_neg_done_seen", 32'(seen),             32'd1);
    check("c_neg_position",  32'(pos_of(0)),        32'h0000_FBA0);
    repeat (3) @(negedge clk_usb);
    check("c_neg_psen",      32'(psen_cnt[0] - p0), 32'd1120);
    check("c_neg_inc",       32'(inc_cnt[0] - i0),  32'd0);

    // ---- Retarget: load +10, switch to +4 together with the 6th PSDONE ----
    mmcm_rst(2'b01);
    lat[0] = 3;
    p0 = psen_cnt[0]; i0 = inc_cnt[0]; d0 = done_cnt[0];
    drive_load(2'b01, 16'd10);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pos_of(0) == 16'd6 && psdone_q[0]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_usb);
    end
    check("d_sixth_psdone", 32'(seen), 32'd1);
    I_step_index[0 +: W] = 16'd4;
    I_load[0] = 1'b1;
    @(negedge clk_usb);
    I_load[0] = 1'b0;
    wait_done(0, 300, seen);
    check("d_done_seen",   32'(seen),             32'd1);
    check("d_position",    32'(pos_of(0)),        32'd4);
    repeat (5) @(negedge clk_usb);
    check("d_psen_pulses", 32'(psen_cnt[0] - p0), 32'd8);
    check("d_inc_pulses",  32'(inc_cnt[0] - i0),  32'd6);
    check("d_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    // ---- Parallel: both channels to +10 with latencies 2 and 7 ----
    mmcm_rst(2'b11);
    lat[0] = 2; lat[1] = 7;
    p0 = psen_cnt[0]; i0 = inc_cnt[0]; d0 = done_cnt[0];
    p1 = psen_cnt[1]; i1 = inc_cnt[1]; d1 = done_cnt[1];
    drive_load(2'b11, 16'd10);
    seen0 = 1'b0; seen1 = 1'b0;
    for (int i = 0; i < 500 && !(seen0 && seen1); i++) begin
      @(negedge clk_usb);
      if (O_done[0]) seen0 = 1'b1;
      if (O_done[1]) seen1 = 1'b1;
    end
    check("e_ch0_done_seen", 32'(seen0), 32'd1);
    check("e_ch1_done_seen", 32'(seen1), 32'd1);
    repeat (3) @(negedge clk_usb);
    check("e_ch0_position", 32'(pos_of(0)),        32'd10);
    check("e_ch1_position", 32'(pos_of(1)),        32'd10);
    check("e_ch0_psen",     32'(psen_cnt[0] - p0), 32'd10);
    check("e_ch1_psen",     32'(psen_cnt[1] - p1), 32'd10);
    check("e_ch0_inc",      32'(inc_cnt[0] - i0),  32'd10);
    check("e_ch1_inc",      32'(inc_cnt[1] - i1),  32'd10);
    check("e_ch0_done",     32'(done_cnt[0] - d0), 32'd1);
    check("e_ch1_done",     32'(done_cnt[1] - d1), 32'd1);

    // Asynchronous reset mid-WAIT, asserted away from any clock edge.
    drive_load(2'b11, 16'd20);
    repeat (4) @(negedge clk_usb);
    check("e_busy_before_reset", 32'(O_busy), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("e_async_psen",     32'(O_psen),     32'd0);
    check("e_async_psincdec", 32'(O_psincdec), 32'd0);
    check("e_async_busy",     32'(O_busy),     32'd0);
    check("e_async_done",     32'(O_done),     32'd0);
    check("e_async_position", O_position,      32'd0);
    @(negedge clk_usb);
    reset = 1'b0;
    repeat (12) @(negedge clk_usb);

    // ---- MMCM reset mid-step: re-zero, no O_done, then a fresh load works ----
    lat[0] = 3;
    d0 = done_cnt[0];
    drive_load(2'b01, 16'd5);
    repeat (6) @(negedge clk_usb);
    mmcm_rst(2'b01);
    check("f_mrst_position", 32'(pos_of(0)), 32'd0);
    check("f_mrst_busy",     32'(O_busy[0]), 32'd0);
    repeat (12) @(negedge clk_usb);
    p0 = psen_cnt[0];
    repeat (4) @(negedge clk_usb);
    check("f_mrst_no_done",  32'(done_cnt[0] - d0), 32'd0);
    check("f_mrst_idle",     32'(psen_cnt[0] - p0), 32'd0);
    check("f_mrst_idle_pos", 32'(pos_of(0)),        32'd0);
    drive_load(2'b01, 16'd2);
    wait_done(0, 200, seen);
    check("f_reload_done",     32'(seen),      32'd1);
    check("f_reload_position", 32'(pos_of(0)), 32'd2);

`ifdef MMCM_PS_TIMEOUT_EN
    // ---- PSDONE withheld: error after TMO WAIT cycles, sticky until MMCM reset ----
    mmcm_rst(2'b01);
    repeat (12) @(negedge clk_usb);
    ps_en[0] = 1'b0;
    p0 = psen_cnt[0]; d0 = done_cnt[0];
    @(negedge clk_usb);
    I_step_index[0 +: W] = 16'd3;
    I_load[0] = 1'b1;
    @(posedge clk_usb);
    @(negedge clk_usb);
    I_load[0] = 1'b0;
    @(posedge clk_usb);
    repeat (TMO - 1) @(posedge clk_usb);
    #1;
    check("g_error_early", 32'(O_error[0]), 32'd0);
    @(posedge clk_usb); #1;
    check("g_error_set",   32'(O_error[0]), 32'd1);
    check("g_error_busy",  32'(O_busy[0]),  32'd0);
    drive_load(2'b01, 16'd5);
    repeat (10) @(negedge clk_usb);
    check("g_load_ignored_psen", 32'(psen_cnt[0] - p0), 32'd1);
    check("g_load_ignored_busy", 32'(O_busy[0]),        32'd0);
    check("g_error_sticky",      32'(O_error[0]),       32'd1);
    check("g_no_done",           32'(done_cnt[0] - d0), 32'd0);
    check("g_position",          32'(pos_of(0)),        32'd1);
    mmcm_rst(2'b01);
    check("g_error_cleared",  32'(O_error[0]), 32'd0);
    check("g_position_zero",  32'(pos_of(0)),  32'd0);
    ps_en[0] = 1'b1;
    drive_load(2'b01, 16'd2);
    wait_done(0, 200, seen);
    check("g_recover_done",     32'(seen),      32'd1);
    check("g_recover_position", 32'(pos_of(0)), 32'd2);
`else
    check("g_error_tied_zero", 32'(O_error), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
